// File: rtl/aes128_round_core.sv
// Iterative AES-128 encryption core: one whitening edge, then one full cipher round per clock.
// Also hosts the shared S-box table and the key-expansion function used to build key_schedule.
package globals_key_expansion;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:1407] fn_key_expansion(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1407] ks;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if ((i % 4) == 0) begin
                t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

endpackage

module aes128_round_core #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:1407] key_schedule,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:127]  plaintext,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:127]  ciphertext,
    output logic          busy
);
    import globals_key_expansion::*;

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q;
    logic [3:0]   rnd_q;
    logic [0:127] st_q;
    logic [0:127] st_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [0:127] rk_sel;
    logic         last_rnd;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];

    assign last_rnd = (rnd_q == 4'(NR));

    // Constant-base key selection keeps every slice in range even for unused rnd codes.
    always_comb begin
        rk_sel = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rnd_q == 4'(r)) rk_sel = key_schedule[128*r +: 128];
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) sb[k] = SBOX[st_q[8*k +: 8]];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int k = 0; k < 16; k++) begin
            st_d[8*k +: 8] = (last_rnd ? sr[k] : mc[k]) ^ rk_sel[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q       <= plaintext ^ key_schedule[0 +: 128];
                        rnd_q      <= 4'd1;
                        state_q    <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    st_q <= st_d;
                    // rnd saturates at NR so it never wraps while parked in DONE
                    if (last_rnd) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        rnd_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rnd_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = st_q;

endmodule

// File: tb/tb_aes128_round_core.sv
// Directed bench for aes128_round_core: known-answer vectors plus handshake, backpressure and reset sequences.
module tb_aes128_round_core;
    import globals_key_expansion::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [0:1407] key_schedule = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:127]  plaintext = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [0:127]  ciphertext;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [0:127] key;
        logic [0:127] pt;
        logic [0:127] wh;
        logic [0:127] ct;
    } vec_t;

    vec_t vecs [3];

    aes128_round_core #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_schedule (key_schedule),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plaintext    (plaintext),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ciphertext   (ciphertext),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Present a block just after a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input string name, input logic [0:127] key, input logic [0:127] pt,
                          input logic [0:127] wh);
        key_schedule = fn_key_expansion(key);
        plaintext    = pt;
        in_valid     = 1'b1;
        chk({name, "_in_ready_pre"}, 128'(in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_whiten"}, ciphertext, wh);
        chk({name, "_busy"}, 128'(busy), 128'd1);
        chk({name, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    endtask

    // Counts edges since accept (accept edge = 1) until out_valid is seen.
    task automatic wait_valid(input string name, output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout got no out_valid exp out_valid within 40 edges", name);
        end
    endtask

    initial begin
        int         n, n1, n2, extra;
        logic [0:127] ct0, ct1, ct2;

        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h00102030405060708090a0b0c0d0e0f0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"zero", 128'h0, 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        #12;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ciphertext", ciphertext, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known-answer table with out_ready held high throughout (also shows early out_ready is harmless)
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].wh);
            wait_valid(vecs[i].name, n);
            chk({vecs[i].name, "_latency"}, 128'(n), 128'd11);
            chk({vecs[i].name, "_ct"}, ciphertext, vecs[i].ct);
            @(posedge clk);
            @(negedge clk);
            chk({vecs[i].name, "_ov_one_cycle"}, 128'(out_valid), 128'd0);
            chk({vecs[i].name, "_in_ready_post"}, 128'(in_ready), 128'd1);
        end

        // Backpressure: 20 stalled cycles in DONE
        out_ready = 1'b0;
        accept("bp", vecs[0].key, vecs[0].pt, vecs[0].wh);
        wait_valid("bp", n);
        chk("bp_latency", 128'(n), 128'd11);
        for (int c = 0; c < 20; c++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ct", ciphertext, vecs[0].ct);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ov_cleared", 128'(out_valid), 128'd0);
        chk("bp_in_ready_post", 128'(in_ready), 128'd1);

        // in_valid toggling with junk plaintext while ROUND/DONE must be ignored
        out_ready = 1'b0;
        accept("ign", vecs[0].key, vecs[0].pt, vecs[0].wh);
        n = 1;
        n1 = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            n++;
            if (out_valid && n1 == 0) n1 = n;
        end
        in_valid = 1'b0;
        chk("ign_latency", 128'(n1), 128'd11);
        chk("ign_ct", ciphertext, vecs[0].ct);
        chk("ign_out_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid || busy) extra++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("ign_single_output", 128'(extra), 128'd0);

        // Back-to-back with in_valid held high
        key_schedule = fn_key_expansion(vecs[0].key);
        plaintext    = vecs[0].pt;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        n1 = 0;
        n2 = 0;
        ct1 = '0;
        ct2 = '0;
        while (n2 == 0 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (out_valid) begin
                if (n1 == 0) begin
                    n1 = n;
                    ct1 = ciphertext;
                    key_schedule = fn_key_expansion(vecs[1].key);
                    plaintext    = vecs[1].pt;
                end else begin
                    n2 = n;
                    ct2 = ciphertext;
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_first_latency", 128'(n1), 128'd11);
        chk("b2b_spacing", 128'(n2 - n1), 128'd12);
        chk("b2b_ct1", ct1, vecs[0].ct);
        chk("b2b_ct2", ct2, vecs[1].ct);
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Asynchronous reset at rnd=5
        accept("rst5", vecs[0].key, vecs[0].pt, vecs[0].wh);
        repeat (4) @(posedge clk);
        #2;
        chk("rst5_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst5_busy", 128'(busy), 128'd0);
        chk("rst5_out_valid", 128'(out_valid), 128'd0);
        chk("rst5_ct", ciphertext, 128'd0);
        chk("rst5_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) extra++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst5_no_pulse", 128'(extra), 128'd0);

        // Reset while parked in DONE with out_valid high
        out_ready = 1'b0;
        accept("rstd", vecs[1].key, vecs[1].pt, vecs[1].wh);
        wait_valid("rstd", n);
        chk("rstd_ct", ciphertext, vecs[1].ct);
        #2;
        rst = 1'b1;
        #1;
        chk("rstd_out_valid", 128'(out_valid), 128'd0);
        chk("rstd_ct_cleared", ciphertext, 128'd0);

        // First edge after reset release accepts a block
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        accept("post", vecs[0].key, vecs[0].pt, vecs[0].wh);
        wait_valid("post", n);
        chk("post_latency", 128'(n), 128'd11);
        ct0 = ciphertext;
        chk("post_ct", ct0, vecs[0].ct);
        @(posedge clk);
        @(negedge clk);
        chk("post_in_ready", 128'(in_ready), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
